// File: rtl/wb_chrono_timer.sv
// wb_chrono_timer: Wishbone classic slave holding a run/stop BCD stopwatch (MM:SS.hh) and display value.
// Optional macro CHRONO_LAP_EN builds the lap capture register and the LAP_VALID status bit.
//
// state   | meaning
// ST_IDLE | no response in flight; a new request may be accepted
// ST_ACK  | ack cycle for the request accepted on the previous edge
// ST_ERR  | err cycle for a rejected write to a read-only register
module wb_chrono_timer #(
    parameter int PRESCALE = 500000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [10:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_cab_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic [15:0] display_o,
    output logic        irq_o
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_TIME   = 2'd2;
    localparam logic [1:0] A_LAP    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   dat_q, dat_d;
    logic          run_q, dsel_q, irqen_q, ovf_q, ovf_d;
    logic [7:0]    hh_q, ss_q, mm_q;
    logic [7:0]    hh_d, ss_d, mm_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   disp_q;
    logic          irq_q;

    logic          req, wr_bad, ctrl_wr, clr, tick;
    logic [1:0]    reg_sel;
    logic [31:0]   rd_data;
    logic [31:0]   lap_word;
    logic          lapv;
    logic [23:0]   time_now;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    assign time_now = {mm_q, ss_q, hh_q};

    // The response flops double as the "busy" flag, so a held strobe is accepted every other cycle.
    assign reg_sel = wb_adr_i[1:0];
    assign req     = wb_cyc_i & wb_stb_i & (state_q == ST_IDLE);
    assign wr_bad  = req & wb_we_i & (reg_sel != A_CTRL);
    assign ctrl_wr = req & wb_we_i & (reg_sel == A_CTRL) & wb_sel_i[0];
    assign clr     = ctrl_wr & wb_dat_i[1];
    assign tick    = run_q & (presc_q == '0);

    always_comb begin
        state_d = ST_IDLE;
        if (req) begin
            state_d = wr_bad ? ST_ERR : ST_ACK;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            A_CTRL:   rd_data = {27'd0, irqen_q, dsel_q, 2'b00, run_q};
            A_STATUS: rd_data = {29'd0, ovf_q, lapv, run_q};
            A_TIME:   rd_data = {8'h00, time_now};
            A_LAP:    rd_data = lap_word;
            default:  rd_data = '0;
        endcase
    end

    assign dat_d = (req & ~wb_we_i) ? rd_data : 32'd0;

    // Prescaler runs down from PRESCALE-1; the zero cycle is the tick, matching an up-count to PRESCALE-1.
    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = PRE_LAST;
        end else if (run_q) begin
            presc_d = (presc_q == '0) ? PRE_LAST : presc_q - 1'b1;
        end
    end

    always_comb begin
        hh_d  = hh_q;
        ss_d  = ss_q;
        mm_d  = mm_q;
        ovf_d = ovf_q;
        if (clr) begin
            hh_d  = 8'h00;
            ss_d  = 8'h00;
            mm_d  = 8'h00;
            ovf_d = 1'b0;
        end else if (tick) begin
            if (hh_q != 8'h99) begin
                hh_d = bcd_inc(hh_q);
            end else begin
                hh_d = 8'h00;
                if (ss_q != 8'h59) begin
                    ss_d = bcd_inc(ss_q);
                end else begin
                    ss_d = 8'h00;
                    if (mm_q != 8'h99) begin
                        mm_d = bcd_inc(mm_q);
                    end else begin
                        mm_d  = 8'h00;
                        ovf_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            dat_q   <= '0;
            run_q   <= 1'b0;
            dsel_q  <= 1'b0;
            irqen_q <= 1'b0;
            ovf_q   <= 1'b0;
            hh_q    <= 8'h00;
            ss_q    <= 8'h00;
            mm_q    <= 8'h00;
            presc_q <= PRE_LAST;
            disp_q  <= 16'h0000;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            ovf_q   <= ovf_d;
            hh_q    <= hh_d;
            ss_q    <= ss_d;
            mm_q    <= mm_d;
            presc_q <= presc_d;
            if (ctrl_wr) begin
                run_q   <= wb_dat_i[0];
                dsel_q  <= wb_dat_i[3];
                irqen_q <= wb_dat_i[4];
            end
            disp_q <= dsel_q ? {mm_q, ss_q} : {ss_q, hh_q};
            irq_q  <= irqen_q & ovf_q;
        end
    end

`ifdef CHRONO_LAP_EN
    logic [23:0] lap_q;
    logic        lapv_q;
    logic        lap_cap, lap_rd;

    assign lap_cap = ctrl_wr & wb_dat_i[2];
    assign lap_rd  = req & ~wb_we_i & (reg_sel == A_LAP);

    // Capture takes priority so a lap taken in the same cycle as a LAP read stays valid.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lap_q  <= '0;
            lapv_q <= 1'b0;
        end else if (lap_cap) begin
            lap_q  <= time_now;
            lapv_q <= 1'b1;
        end else if (lap_rd) begin
            lapv_q <= 1'b0;
        end
    end

    assign lap_word = {8'h00, lap_q};
    assign lapv     = lapv_q;

    logic unused_bits;
    assign unused_bits = ^{wb_cab_i, wb_adr_i[10:2], wb_sel_i[3:1], wb_dat_i[31:5]};
`else
    assign lap_word = 32'd0;
    assign lapv     = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{wb_cab_i, wb_adr_i[10:2], wb_sel_i[3:1], wb_dat_i[31:5], wb_dat_i[2]};
`endif

    assign wb_ack_o  = (state_q == ST_ACK);
    assign wb_err_o  = (state_q == ST_ERR);
    assign wb_rty_o  = 1'b0;
    assign wb_dat_o  = dat_q;
    assign display_o = disp_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_chrono_timer.sv
// tb_wb_chrono_timer: scoreboard bench; the reference keeps time as a centisecond count and
// converts to BCD only when a value is observed.
module tb_wb_chrono_timer;

    localparam int PRESCALE = 4;
    localparam int T_MAX    = 599999;
`ifdef CHRONO_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [10:0] adr;
    logic [3:0]  sel;
    logic        we, cyc, stb, cab;
    logic        ack, err, rty, irq;
    logic [15:0] disp;

    always #5 clk = ~clk;

    wb_chrono_timer #(.PRESCALE(PRESCALE)) dut (
        .clk_i(clk), .rst_i(rst),
        .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_adr_i(adr), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cab_i(cab),
        .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty),
        .display_o(disp), .irq_o(irq)
    );

    typedef struct packed {
        logic        err;
        logic        rd;
        logic [31:0] dat;
    } exp_t;

    exp_t sb_q[$];

    // reference model state
    logic        m_resp = 0, m_run = 0, m_dsel = 0, m_irqen = 0, m_ovf = 0, m_lapv = 0, m_irq = 0;
    int          m_pre = 0, m_t = 0, m_lap = 0;
    logic [15:0] m_disp = 0;
    logic        pl_req = 0;
    int          pl_val = 0;
    logic [31:0] pl_w = 0;
    logic        done = 0;
    int          n_total = 0, n_bad = 0;
    logic        prev_ack = 0;

    function automatic logic [7:0] bcd(input int x);
        logic [3:0] a, b;
        a = 4'(x / 10);
        b = 4'(x % 10);
        return {a, b};
    endfunction

    function automatic logic [31:0] t2w(input int t);
        return {8'h00, bcd(t / 6000), bcd((t / 100) % 60), bcd(t % 100)};
    endfunction

    int          m_tv;
    logic [31:0] m_tw;
    assign m_tv = pl_req ? pl_val : m_t;
    assign m_tw = t2w(m_tv);

    wire b_req  = cyc & stb & ~m_resp;
    wire b_bad  = b_req & we & (adr[1:0] != 2'd0);
    wire b_cw   = b_req & we & (adr[1:0] == 2'd0) & sel[0];
    wire b_clr  = b_cw & dat_i[1];
    wire b_lap  = b_cw & dat_i[2] & LAP_EN;
    wire b_lrd  = b_req & ~we & (adr[1:0] == 2'd3);
    wire b_tick = m_run & (m_pre == PRESCALE - 1);

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        case (a)
            2'd0:    r = {27'd0, m_irqen, m_dsel, 2'b00, m_run};
            2'd1:    r = {29'd0, m_ovf, m_lapv, m_run};
            2'd2:    r = m_tw;
            default: r = LAP_EN ? t2w(m_lap) : 32'd0;
        endcase
        return r;
    endfunction

    function automatic exp_t make_exp(input logic e, input logic r, input logic [31:0] d);
        exp_t x;
        x.err = e;
        x.rd  = r;
        x.dat = r ? d : 32'd0;
        return x;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_resp  <= 0; m_run <= 0; m_dsel <= 0; m_irqen <= 0; m_ovf <= 0;
            m_lapv  <= 0; m_irq <= 0; m_pre <= 0; m_t <= 0; m_lap <= 0; m_disp <= 0;
            sb_q.delete();
        end else begin
            m_resp <= b_req;
            if (b_req) sb_q.push_back(make_exp(b_bad, ~we, model_read(adr[1:0])));
            if (b_clr)       m_t <= 0;
            else if (b_tick) m_t <= (m_tv == T_MAX) ? 0 : m_tv + 1;
            else             m_t <= m_tv;
            if (b_clr)       m_pre <= 0;
            else if (m_run)  m_pre <= (m_pre == PRESCALE - 1) ? 0 : m_pre + 1;
            if (b_clr)                           m_ovf <= 0;
            else if (b_tick && m_tv == T_MAX)    m_ovf <= 1;
            if (b_cw) begin
                m_run   <= dat_i[0];
                m_dsel  <= dat_i[3];
                m_irqen <= dat_i[4];
            end
            if (b_lap) begin
                m_lap  <= m_tv;
                m_lapv <= 1;
            end else if (b_lrd) begin
                m_lapv <= 0;
            end
            m_irq  <= m_irqen & m_ovf;
            m_disp <= m_dsel ? m_tw[23:8] : m_tw[15:0];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total = n_total + 1;
        if (got !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (m_resp) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("resp_ack", {31'd0, ack}, {31'd0, ~e.err});
                check("resp_err", {31'd0, err}, {31'd0, e.err});
                if (e.rd) check("read_data", dat_o, e.dat);
            end
        end else begin
            check("idle_bus", {dat_o[31:2], ack, err}, 32'd0);
        end
        check("display", {16'd0, disp}, {16'd0, m_disp});
        check("irq", {31'd0, irq}, {31'd0, m_irq});
        check("rty", {31'd0, rty}, 32'd0);
        if (ack && prev_ack) check("ack_twice", 32'd1, 32'd0);
        prev_ack = ack;
        if (done) begin
            check("sb_drain", sb_q.size(), 32'd0);
            $display("test done: total=%0d bad=%0d", n_total, n_bad);
            $finish;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int hold);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; dat_i = d; sel = s;
        adr = {9'($urandom), a};
        cab = 1'($urandom);
        repeat (hold) @(negedge clk);
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b1, a, d, 4'hF, 1);
    endtask

    task automatic rd(input logic [1:0] a);
        bus(1'b0, a, $urandom, 4'($urandom), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Loads a time value while RUN=0; the forced value is written back by the hold path before release.
    task automatic preload(input int t);
        @(negedge clk);
        pl_w   = t2w(t);
        pl_val = t;
        pl_req = 1;
        force dut.hh_q = pl_w[7:0];
        force dut.ss_q = pl_w[15:8];
        force dut.mm_q = pl_w[23:16];
        @(negedge clk);
        release dut.hh_q;
        release dut.ss_q;
        release dut.mm_q;
        pl_req = 0;
    endtask

    initial begin
        rst = 0; cyc = 0; stb = 0; we = 0; cab = 0; adr = 0; sel = 0; dat_i = 0;
        idle(3);
        rst = 1;
        rd(1); rd(2); rd(0); rd(3);

        // count and freeze
        wr(0, 32'h1); idle(400); rd(2); rd(1);
        wr(0, 32'h0); rd(2); idle(100); rd(2);

        // errors, masked write, back-to-back strobes
        wr(2, 32'hFFFF_FFFF); wr(1, 32'h7); wr(3, 32'h7); rd(2);
        bus(1'b1, 2'd0, 32'h0000_001F, 4'b1110, 1); rd(0); rd(1);
        bus(1'b0, 2'd2, 32'd0, 4'hF, 4);
        bus(1'b1, 2'd0, 32'h0000_0001, 4'hF, 3);
        bus(1'b1, 2'd1, 32'h0, 4'hF, 4);
        wr(0, 32'h0); idle(3);

        // display select
        preload(1 * 6000 + 23 * 100 + 45);
        wr(0, 32'h0); idle(2); wr(0, 32'h8); idle(2); rd(2); wr(0, 32'h0); idle(2);

        // lap
        preload(12 * 100 + 34);
        wr(0, 32'h05); idle(10); rd(1); rd(3); rd(1); idle(7);
        wr(0, 32'h07); rd(3); rd(2); rd(1); wr(0, 32'h0);

        // wrap, overflow and irq
        wr(0, 32'h10); preload(T_MAX - 1);
        wr(0, 32'h11); idle(12); rd(2); rd(1);
        wr(0, 32'h13); idle(3); rd(1); rd(2);
        wr(0, 32'h01); idle(5); wr(0, 32'h00); idle(3);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int op;
            op = $urandom_range(0, 11);
            if (op < 5) begin
                bus(1'b0, 2'($urandom), $urandom, 4'($urandom), $urandom_range(1, 4));
            end else if (op < 9) begin
                bus(1'b1, 2'd0, {$urandom_range(0, 255) == 0 ? 27'h7FFFFFF : 27'($urandom), 5'($urandom) & 5'b11011 | (($urandom_range(0, 5) == 0) ? 5'b00100 : 5'b0) | (($urandom_range(0, 7) == 0) ? 5'b00010 : 5'b0)},
                    4'($urandom), $urandom_range(1, 3));
            end else if (op < 10) begin
                bus(1'b1, 2'($urandom_range(1, 3)), $urandom, 4'($urandom), 1);
            end else if (op < 11) begin
                wr(0, {27'd0, 1'($urandom), 1'($urandom), 3'b000});
                preload(T_MAX - $urandom_range(0, 3));
                wr(0, {27'd0, 1'($urandom), 1'($urandom), 3'b001});
            end
            idle($urandom_range(0, 20));
        end

        // reset in the middle of activity with a request pending
        wr(0, 32'h19); idle(20);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 11'd2; rst = 0;
        idle(2);
        rst = 1; cyc = 0; stb = 0;
        rd(1); rd(2); rd(0); idle(4);

        done = 1;
        idle(5);
    end

endmodule
